// File: rtl/spi_regbank.sv
// rtl/spi_regbank.sv - oversampled SPI-slave register bank with config, status and sticky W1C bits
//
// Purpose:
//   SPI slave (modes 0-3) sampled entirely in the clk domain. A frame is one
//   command byte {wr, addr[6:0]} followed by any number of REG_WIDTH-bit data
//   words; the address auto-increments after every complete word and wraps
//   127 -> 0. Addresses 0..NUM_CFG-1 are config registers, the next NUM_STATUS
//   addresses are status registers, and everything above reads 0.
//
// Ports:
//   clk, rstb      system clock, asynchronous active-low reset
//   ena            block enable; low forces IDLE and blocks writes
//   mode           SPI mode {CPOL, CPHA}
//   spi_cs_n       chip select (async, active-low)
//   spi_clk        SPI clock (async)
//   spi_mosi       serial data in, MSB first
//   spi_miso       serial data out, MSB first
//   config_regs    packed config registers, reg k at [k*REG_WIDTH +: REG_WIDTH]
//   cfg_wr_strobe  one-cycle pulse per written config register
//   status_regs    packed status inputs, same packing
//   irq            registered OR of all latched sticky bits

module spi_regbank #(
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8,
    parameter int REG_WIDTH  = 8,
    parameter logic [NUM_CFG*REG_WIDTH-1:0]    CFG_RESET   = '0,
    parameter logic [NUM_STATUS*REG_WIDTH-1:0] STICKY_MASK = '0
) (
    input  logic                             clk,
    input  logic                             rstb,
    input  logic                             ena,
    input  logic [1:0]                       mode,
    input  logic                             spi_cs_n,
    input  logic                             spi_clk,
    input  logic                             spi_mosi,
    output logic                             spi_miso,
    output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
    output logic [NUM_CFG-1:0]               cfg_wr_strobe,
    input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs,
    output logic                             irq
);

    localparam int W  = REG_WIDTH;
    localparam int CW = NUM_CFG * W;
    localparam int SW = NUM_STATUS * W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [1:0]   r_cs_sync;
    logic         r_cs_prev;
    logic [1:0]   r_sclk_sync;
    logic         r_sclk_prev;
    logic [1:0]   r_mosi_sync;

    logic [4:0]   r_bit_cnt;
    logic [W-2:0] r_rx;
    logic [W-1:0] r_tx;
    logic         r_miso;
    logic         r_wr;
    logic [6:0]   r_addr;

    logic [CW-1:0]      r_cfg;
    logic [NUM_CFG-1:0] r_strobe;
    logic [SW-1:0]      r_sticky;
    logic               r_irq;

    logic         w_cs;
    logic         w_cs_fall;
    logic         w_sclk;
    logic         w_mosi;
    logic         w_rise;
    logic         w_fall;
    logic         w_lead;
    logic         w_trail;
    logic         w_sample;
    logic         w_shift;
    logic         w_active;
    logic         w_in_cmd;
    logic         w_in_data;
    logic         w_miso_en;
    logic         w_cmd_done;
    logic         w_word_done;
    logic [W-1:0] w_rx_word;
    logic [6:0]   w_rd_addr;
    logic [W-1:0] w_rd_data;
    logic [SW-1:0]      w_status_view;
    logic [SW-1:0]      w_clr;
    logic [NUM_CFG-1:0] w_cfg_we;

    // CS synchroniser resets to "selected" so that CS already held low when
    // reset is released does not look like a falling edge: a new frame needs
    // a genuine high-to-low transition.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cs_sync   <= 2'b00;
            r_cs_prev   <= 1'b0;
            r_sclk_sync <= 2'b00;
            r_sclk_prev <= 1'b0;
            r_mosi_sync <= 2'b00;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], spi_cs_n};
            r_cs_prev   <= r_cs_sync[1];
            r_sclk_sync <= {r_sclk_sync[0], spi_clk};
            r_sclk_prev <= r_sclk_sync[1];
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
        end
    end

    assign w_cs      = r_cs_sync[1];
    assign w_cs_fall = r_cs_prev & ~w_cs;
    assign w_sclk    = r_sclk_sync[1];
    assign w_mosi    = r_mosi_sync[1];
    assign w_rise    = w_sclk & ~r_sclk_prev;
    assign w_fall    = ~w_sclk & r_sclk_prev;

    // CPOL picks which physical edge leads; CPHA picks which edge samples.
    assign w_lead    = mode[1] ? w_fall : w_rise;
    assign w_trail   = mode[1] ? w_rise : w_fall;
    assign w_sample  = mode[0] ? w_trail : w_lead;
    assign w_shift   = mode[0] ? w_lead : w_trail;
    assign w_active  = ena & ~w_cs;

    assign w_rx_word   = {r_rx, w_mosi};
    assign w_cmd_done  = w_in_cmd & w_sample & (r_bit_cnt == 5'd7);
    assign w_word_done = w_in_data & w_sample & (r_bit_cnt == 5'(W - 1));

    // FSM: state register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (ena && w_cs_fall) w_state_nxt = S_CMD;
            S_CMD:   if (!w_active)        w_state_nxt = S_IDLE;
                     else if (w_cmd_done)  w_state_nxt = S_DATA;
            S_DATA:  if (!w_active)        w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_in_cmd  = 1'b0;
        w_in_data = 1'b0;
        w_miso_en = 1'b0;
        case (r_state)
            S_CMD:   w_in_cmd = w_active;
            S_DATA: begin
                w_in_data = w_active;
                w_miso_en = w_active;
            end
            default: ;
        endcase
    end

    // Serial receive path: counter and shift register only run inside a frame,
    // so a CS rise or ena drop throws away any partial word.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_bit_cnt <= '0;
            r_rx      <= '0;
        end else if (!(w_in_cmd || w_in_data)) begin
            r_bit_cnt <= '0;
        end else if (w_sample) begin
            r_rx      <= w_rx_word[W-2:0];
            r_bit_cnt <= (w_cmd_done || w_word_done) ? 5'd0 : r_bit_cnt + 5'd1;
        end
    end

    // Address of the word about to be transmitted: the command address when
    // the command byte completes, otherwise the next sequential address.
    assign w_rd_addr     = w_cmd_done ? w_rx_word[6:0] : r_addr + 7'd1;
    assign w_status_view = (status_regs & ~STICKY_MASK) | r_sticky;

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_CFG; k++)
            if (w_rd_addr == 7'(k)) w_rd_data = r_cfg[k*W +: W];
        for (int s = 0; s < NUM_STATUS; s++)
            if (w_rd_addr == 7'(NUM_CFG + s)) w_rd_data = w_status_view[s*W +: W];
    end

    // Transmit path: snapshot on the sample edge completing a byte/word, then
    // the opposite edge presents the next bit. For CPHA=0 this places the MSB
    // after the trailing edge of the last command bit; for CPHA=1 on the
    // leading edge of the first data bit.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_tx   <= '0;
            r_miso <= 1'b0;
        end else begin
            if (!w_in_data) r_miso <= 1'b0;
            if (w_cmd_done) begin
                r_wr   <= w_rx_word[7];
                r_addr <= w_rx_word[6:0];
                r_tx   <= w_rx_word[7] ? '0 : w_rd_data;
            end else if (w_word_done) begin
                r_addr <= r_addr + 7'd1;
                r_tx   <= r_wr ? '0 : w_rd_data;
            end else if (w_in_data && w_shift) begin
                r_miso <= r_tx[W-1];
                r_tx   <= {r_tx[W-2:0], 1'b0};
            end
        end
    end

    // Write decode for a completed data word.
    always_comb begin
        w_cfg_we = '0;
        w_clr    = '0;
        if (w_word_done && r_wr) begin
            for (int k = 0; k < NUM_CFG; k++)
                if (r_addr == 7'(k)) w_cfg_we[k] = 1'b1;
            for (int s = 0; s < NUM_STATUS; s++)
                if (r_addr == 7'(NUM_CFG + s))
                    w_clr[s*W +: W] = w_rx_word & STICKY_MASK[s*W +: W];
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cfg    <= CFG_RESET;
            r_strobe <= '0;
        end else begin
            r_strobe <= w_cfg_we;
            for (int k = 0; k < NUM_CFG; k++)
                if (w_cfg_we[k]) r_cfg[k*W +: W] <= w_rx_word;
        end
    end

    // Set is OR'd in after the clear so a bit held high survives a W1C.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_sticky <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_sticky <= ((r_sticky & ~w_clr) | status_regs) & STICKY_MASK;
            r_irq    <= |r_sticky;
        end
    end

    assign spi_miso      = r_miso & w_miso_en;
    assign config_regs   = r_cfg;
    assign cfg_wr_strobe = r_strobe;
    assign irq           = r_irq;

endmodule

// File: tb/tb_spi_regbank.sv
// tb/tb_spi_regbank.sv - scoreboard testbench for spi_regbank
module tb_spi_regbank;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rstb;
    logic        ena;
    logic [1:0]  mode;
    logic        spi_cs_n;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;
    logic [31:0] config_regs;
    logic [3:0]  cfg_wr_strobe;
    logic [15:0] status_in;
    logic        irq;

    always #5 clk = ~clk;

    spi_regbank #(
        .NUM_CFG    (4),
        .NUM_STATUS (2),
        .REG_WIDTH  (8),
        .CFG_RESET  (32'h04030201),
        .STICKY_MASK(16'h0001)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .ena          (ena),
        .mode         (mode),
        .spi_cs_n     (spi_cs_n),
        .spi_clk      (spi_clk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .config_regs  (config_regs),
        .cfg_wr_strobe(cfg_wr_strobe),
        .status_regs  (status_in),
        .irq          (irq)
    );

    logic [35:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  got_q[$];
    int          chk_id_q[$];
    logic [31:0] chk_exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          done = 0;
    logic [7:0]  tx_bytes [0:7];

    string nm [0:5] = '{"config_regs", "irq", "spi_miso", "cfg_wr_strobe",
                        "pending_writes", "pending_reads"};

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input int id, input logic [31:0] e);
        chk_id_q.push_back(id);
        chk_exp_q.push_back(e);
    endtask

    // Drive one frame of nbytes bytes from tx_bytes. stop_bit/ena_bit/rst_bit
    // (bit indices, -1 = unused) inject a CS abort, ena drop or reset.
    task automatic spi_frame(input logic [1:0] m, input int nbytes,
                             input int stop_bit, input int ena_bit, input int rst_bit);
        logic       cpol;
        logic       cpha;
        logic       bitv;
        logic [7:0] rxb;
        int         nbits;
        logic [7:0] cur;
        mode = m;
        cpol = m[1];
        cpha = m[0];
        rxb  = 8'h00;
        spi_clk = cpol;
        wait_clk(8);
        spi_cs_n = 1'b0;
        wait_clk(8);
        nbits = nbytes * 8;
        if (stop_bit >= 0 && stop_bit < nbits) nbits = stop_bit;
        for (int b = 0; b < nbits; b++) begin
            if (b == ena_bit) begin
                ena = 1'b0;
                wait_clk(2);
                chk(2, 32'd0);
            end
            if (b == rst_bit) begin
                rstb = 1'b0;
                wait_clk(2);
                rstb = 1'b1;
            end
            cur  = tx_bytes[b / 8];
            bitv = cur[7 - (b % 8)];
            if (!cpha) begin
                spi_mosi = bitv;
                wait_clk(H);
                rxb = {rxb[6:0], spi_miso};
                spi_clk = ~cpol;
                wait_clk(H);
                spi_clk = cpol;
            end else begin
                spi_clk  = ~cpol;
                spi_mosi = bitv;
                wait_clk(H);
                rxb = {rxb[6:0], spi_miso};
                spi_clk = cpol;
                wait_clk(H);
            end
            cur = tx_bytes[0];
            if ((b % 8) == 7 && b >= 8 && !cur[7]) got_q.push_back(rxb);
        end
        wait_clk(8);
        spi_cs_n = 1'b1;
        wait_clk(8);
        ena = 1'b1;
    endtask

    task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
        for (int i = 0; i < 8; i++) tx_bytes[i] = 8'hFF;
        tx_bytes[0] = b0;
        tx_bytes[1] = b1;
        tx_bytes[2] = b2;
        tx_bytes[3] = b3;
    endtask

    // Monitor / scoreboard
    initial begin
        logic [35:0] e;
        logic [7:0]  g;
        logic [7:0]  r;
        logic [31:0] act;
        logic [31:0] ex;
        int          id;
        forever begin
            @(negedge clk);
            if (cfg_wr_strobe !== 4'b0000) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected got strobe=%b cfg=%h required no write",
                             cfg_wr_strobe, config_regs);
                end else begin
                    e = exp_wr_q.pop_front();
                    if ({cfg_wr_strobe, config_regs} !== e) begin
                        errors++;
                        $display("FAIL wr_commit got strobe=%b cfg=%h required strobe=%b cfg=%h",
                                 cfg_wr_strobe, config_regs, e[35:32], e[31:0]);
                    end
                end
            end
            while (got_q.size() > 0) begin
                g = got_q.pop_front();
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected got %h required none", g);
                end else begin
                    r = exp_rd_q.pop_front();
                    if (g !== r) begin
                        errors++;
                        $display("FAIL rd_word got %h required %h", g, r);
                    end
                end
            end
            while (chk_id_q.size() > 0) begin
                id = chk_id_q.pop_front();
                ex = chk_exp_q.pop_front();
                case (id)
                    0:       act = config_regs;
                    1:       act = {31'd0, irq};
                    2:       act = {31'd0, spi_miso};
                    3:       act = {28'd0, cfg_wr_strobe};
                    4:       act = exp_wr_q.size();
                    default: act = exp_rd_q.size() + got_q.size();
                endcase
                checks++;
                if (act !== ex) begin
                    errors++;
                    $display("FAIL %s got %h required %h", nm[id], act, ex);
                end
            end
            if (done && chk_id_q.size() == 0) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL timeout got no finish required finish within 80000 cycles");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        rstb      = 1'b0;
        ena       = 1'b1;
        mode      = 2'b00;
        spi_cs_n  = 1'b1;
        spi_clk   = 1'b0;
        spi_mosi  = 1'b0;
        status_in = 16'h7E50;
        set_tx(8'h00, 8'h00, 8'h00, 8'h00);
        wait_clk(4);
        rstb = 1'b1;
        wait_clk(4);
        chk(0, 32'h04030201);
        chk(1, 32'd0);
        chk(2, 32'd0);
        chk(3, 32'd0);
        wait_clk(2);

        // Burst write cfg1/cfg2 in every mode
        for (int m = 0; m < 4; m++) begin
            exp_wr_q.push_back({4'b0010, (m == 0) ? 32'h0403A501 : 32'h043CA501});
            exp_wr_q.push_back({4'b0100, 32'h043CA501});
            set_tx(8'h81, 8'hA5, 8'h3C, 8'hFF);
            spi_frame(2'(m), 3, -1, -1, -1);
        end

        // Burst read across config, status and one unmapped address
        exp_rd_q.push_back(8'h01);
        exp_rd_q.push_back(8'hA5);
        exp_rd_q.push_back(8'h3C);
        exp_rd_q.push_back(8'h04);
        exp_rd_q.push_back(8'h50);
        exp_rd_q.push_back(8'h7E);
        exp_rd_q.push_back(8'h00);
        set_tx(8'h00, 8'hFF, 8'hFF, 8'hFF);
        spi_frame(2'b00, 8, -1, -1, -1);

        // Wrap 127 -> 0
        exp_rd_q.push_back(8'h00);
        exp_rd_q.push_back(8'h01);
        set_tx(8'h7F, 8'hFF, 8'hFF, 8'hFF);
        spi_frame(2'b01, 3, -1, -1, -1);

        // Sticky capture of a one-cycle pulse
        @(negedge clk) status_in[0] = 1'b1;
        @(negedge clk) status_in[0] = 1'b0;
        wait_clk(2);
        chk(1, 32'd1);
        exp_rd_q.push_back(8'h51);
        set_tx(8'h04, 8'hFF, 8'hFF, 8'hFF);
        spi_frame(2'b10, 2, -1, -1, -1);

        // W1C clear
        set_tx(8'h84, 8'h01, 8'hFF, 8'hFF);
        spi_frame(2'b10, 2, -1, -1, -1);
        chk(1, 32'd0);
        exp_rd_q.push_back(8'h50);
        set_tx(8'h04, 8'hFF, 8'hFF, 8'hFF);
        spi_frame(2'b10, 2, -1, -1, -1);

        // Clear while input held high: set wins
        status_in[0] = 1'b1;
        set_tx(8'h84, 8'h01, 8'hFF, 8'hFF);
        spi_frame(2'b11, 2, -1, -1, -1);
        exp_rd_q.push_back(8'h51);
        set_tx(8'h04, 8'hFF, 8'hFF, 8'hFF);
        spi_frame(2'b11, 2, -1, -1, -1);
        chk(1, 32'd1);
        status_in[0] = 1'b0;
        set_tx(8'h84, 8'h01, 8'hFF, 8'hFF);
        spi_frame(2'b00, 2, -1, -1, -1);
        chk(1, 32'd0);

        // CS abort after 5 data bits
        set_tx(8'h80, 8'h5A, 8'hFF, 8'hFF);
        spi_frame(2'b00, 2, 13, -1, -1);
        chk(0, 32'h043CA501);
        chk(2, 32'd0);

        // ena dropped mid-word
        set_tx(8'h83, 8'hFF, 8'hFF, 8'hFF);
        spi_frame(2'b00, 2, -1, 11, -1);
        chk(0, 32'h043CA501);
        chk(2, 32'd0);

        // Reset in the middle of a burst; first word commits beforehand
        exp_wr_q.push_back({4'b0001, 32'h043CA511});
        set_tx(8'h80, 8'h11, 8'h22, 8'h33);
        spi_frame(2'b00, 4, -1, -1, 20);
        chk(0, 32'h04030201);
        chk(1, 32'd0);
        chk(2, 32'd0);
        chk(3, 32'd0);

        // Normal frames after reset
        exp_wr_q.push_back({4'b0100, 32'h04770201});
        set_tx(8'h82, 8'h77, 8'hFF, 8'hFF);
        spi_frame(2'b00, 2, -1, -1, -1);
        exp_rd_q.push_back(8'h77);
        set_tx(8'h02, 8'hFF, 8'hFF, 8'hFF);
        spi_frame(2'b00, 2, -1, -1, -1);

        wait_clk(10);
        chk(4, 32'd0);
        chk(5, 32'd0);
        done = 1'b1;
    end

endmodule
